// File: rtl/cnn_run_controller_if.sv
// rtl/cnn_run_controller_if.sv - CNN start/done/result and result-stream bundle for the run controller
interface cnn_run_controller_if #(
  parameter int FC_OUTPUTS = 2,
  parameter int DATA_WIDTH = 16
);
  localparam int IDX_W = (FC_OUTPUTS > 1) ? $clog2(FC_OUTPUTS) : 1;

  logic                               cnn_start;
  logic                               cnn_done;
  logic [FC_OUTPUTS*DATA_WIDTH-1:0]   cnn_result_flat;
  logic                               out_valid;
  logic                               out_ready;
  logic signed [DATA_WIDTH-1:0]       out_data;
  logic [IDX_W-1:0]                   out_index;
  logic                               out_last;

  modport master (
    output cnn_start,
    input  cnn_done,
    input  cnn_result_flat,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  cnn_start,
    output cnn_done,
    output cnn_result_flat,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );
endinterface

// File: rtl/cnn_run_controller.sv
// rtl/cnn_run_controller.sv - Launches one CNN inference, guards done with a timeout, streams results and reports argmax
module cnn_run_controller #(
  parameter int FC_OUTPUTS     = 2,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IDX_W         = (FC_OUTPUTS > 1) ? $clog2(FC_OUTPUTS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  cnn_run_controller_if.master bus,
  output logic [IDX_W-1:0]     class_idx,
  output logic                 class_valid,
  output logic                 busy,
  output logic                 timeout_err
);
  typedef enum logic [1:0] {IDLE, WAIT_DONE, STREAM} state_t;

  localparam int               CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FC_OUTPUTS - 1);

  state_t                       state_q, state_n;
  logic [CNT_W-1:0]             cnt_q;
  logic signed [DATA_WIDTH-1:0] res_buf [FC_OUTPUTS];
  logic signed [DATA_WIDTH-1:0] max_q;
  logic [IDX_W-1:0]             argmax_q;
  logic                         start_q, valid_q, last_q;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]             index_q;

  logic                         fire, timed_out, beat_gt;
  logic [IDX_W-1:0]             next_idx;

  assign fire      = valid_q && bus.out_ready;
  assign timed_out = TO_EN && (cnt_q == CNT_MAX);
  // Strict greater-than so a tie keeps the earlier (lower) index.
  assign beat_gt   = res_buf[index_q] > max_q;
  assign next_idx  = index_q + IDX_W'(1);

  assign bus.cnn_start = start_q;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_index = index_q;
  assign bus.out_last  = last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:      if (run_req) state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (bus.cnn_done)   state_n = STREAM;
        else if (timed_out) state_n = IDLE;
      end
      STREAM:    if (fire && last_q) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < FC_OUTPUTS; i++) res_buf[i] <= '0;
      max_q       <= '0;
      argmax_q    <= '0;
      start_q     <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      index_q     <= '0;
      last_q      <= 1'b0;
      class_idx   <= '0;
      class_valid <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Status outputs follow the next state so they are registered yet aligned with it.
      start_q     <= (state_n == WAIT_DONE);
      valid_q     <= (state_n == STREAM);
      busy        <= (state_n != IDLE);
      class_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run_req) begin
            cnt_q       <= '0;
            timeout_err <= 1'b0;
          end
        end
        WAIT_DONE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus.cnn_done) begin
            for (int i = 0; i < FC_OUTPUTS; i++)
              res_buf[i] <= bus.cnn_result_flat[i*DATA_WIDTH +: DATA_WIDTH];
            data_q   <= bus.cnn_result_flat[DATA_WIDTH-1:0];
            max_q    <= bus.cnn_result_flat[DATA_WIDTH-1:0];
            argmax_q <= '0;
            index_q  <= '0;
            last_q   <= (LAST_IDX == '0);
          end else if (timed_out) begin
            timeout_err <= 1'b1;
          end
        end
        STREAM: begin
          if (fire) begin
            if (beat_gt) begin
              max_q    <= res_buf[index_q];
              argmax_q <= index_q;
            end
            if (last_q) begin
              class_idx   <= beat_gt ? index_q : argmax_q;
              class_valid <= 1'b1;
            end else begin
              index_q <= next_idx;
              data_q  <= res_buf[next_idx];
              last_q  <= (next_idx == LAST_IDX);
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_run_controller.sv
// tb/tb_cnn_run_controller.sv - Randomized self-checking bench for cnn_run_controller
module tb_cnn_run_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run_req = 1'b0;
  logic        cnn_done = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] flat = '0;

  logic m_class, m_cv, m_busy, m_err;
  logic t_class, t_cv, t_busy, t_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cnn_run_controller_if #(.FC_OUTPUTS(2), .DATA_WIDTH(16)) m_if ();
  cnn_run_controller_if #(.FC_OUTPUTS(2), .DATA_WIDTH(16)) t_if ();

  assign m_if.cnn_done        = cnn_done;
  assign m_if.cnn_result_flat = flat;
  assign m_if.out_ready       = out_ready;
  assign t_if.cnn_done        = cnn_done;
  assign t_if.cnn_result_flat = flat;
  assign t_if.out_ready       = out_ready;

  cnn_run_controller #(.FC_OUTPUTS(2), .DATA_WIDTH(16), .TIMEOUT_CYCLES(4096)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .bus(m_if),
    .class_idx(m_class), .class_valid(m_cv), .busy(m_busy), .timeout_err(m_err)
  );

  cnn_run_controller #(.FC_OUTPUTS(2), .DATA_WIDTH(16), .TIMEOUT_CYCLES(8)) dut_tmo (
    .clk(clk), .reset(reset), .run_req(run_req), .bus(t_if),
    .class_idx(t_class), .class_valid(t_cv), .busy(t_busy), .timeout_err(t_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run_req = 1'b0; cnn_done = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  // One full run on the main instance checked against an argmax computed from the word list.
  // rmode: 0 = ready always high, 1 = random ready, 2 = low three cycles then toggling.
  task automatic run_and_check(input logic signed [15:0] w0, input logic signed [15:0] w1,
                               input int dly, input int rmode, input bit hold,
                               input bit started, input logic [31:0] post);
    logic signed [15:0] w [2];
    int  exp_cls, idx, guard;
    bit  rdy;
    w[0] = w0; w[1] = w1;
    exp_cls = 0;
    for (int i = 1; i < 2; i++) if (w[i] > w[exp_cls]) exp_cls = i;
    flat = {w1, w0};
    out_ready = 1'b0;
    if (!started) begin
      run_req = 1'b1;
      tick();
      if (!hold) run_req = 1'b0;
    end
    for (int i = 0; i <= dly; i++) begin
      n_cmp++;
      if (m_if.cnn_start !== 1'b1 || m_busy !== 1'b1 || m_if.out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL wait_window cycle %0d: start=%b busy=%b valid=%b, required 1 1 0",
                 i, m_if.cnn_start, m_busy, m_if.out_valid);
      end
      if (i == dly) cnn_done = 1'b1;
      tick();
    end
    cnn_done = 1'b0;
    flat = post;
    idx = 0; guard = 0;
    while (idx < 2 && guard < 100) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(1));
        default: rdy = (guard >= 3) && (((guard - 3) % 2) == 0);
      endcase
      out_ready = rdy;
      n_cmp++;
      if (m_if.out_valid !== 1'b1 || m_if.out_data !== w[idx] || m_if.out_index !== 1'(idx) ||
          m_if.out_last !== (idx == 1) || m_if.cnn_start !== 1'b0) begin
        n_bad++;
        $display("FAIL stream beat %0d: valid=%b data=%0d index=%0d last=%b start=%b, required valid=1 data=%0d index=%0d last=%b start=0",
                 idx, m_if.out_valid, m_if.out_data, m_if.out_index, m_if.out_last, m_if.cnn_start,
                 w[idx], idx, (idx == 1));
      end
      tick();
      if (rdy) idx++;
      guard++;
    end
    out_ready = 1'b0;
    if (guard >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL stream_budget: %0d beats accepted, required 2", idx);
    end
    n_cmp++;
    if (m_if.out_valid !== 1'b0 || m_busy !== 1'b0 || m_cv !== 1'b1 || m_class !== 1'(exp_cls)) begin
      n_bad++;
      $display("FAIL run_end: valid=%b busy=%b class_valid=%b class_idx=%0d, required 0 0 1 %0d",
               m_if.out_valid, m_busy, m_cv, m_class, exp_cls);
    end
    tick();
    n_cmp++;
    if (m_cv !== 1'b0 || m_if.cnn_start !== hold || m_busy !== hold) begin
      n_bad++;
      $display("FAIL after_run: class_valid=%b start=%b busy=%b, required 0 %b %b",
               m_cv, m_if.cnn_start, m_busy, hold, hold);
    end
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    n_cmp++;
    if ({m_if.cnn_start, m_if.out_valid, m_if.out_data, m_if.out_index, m_if.out_last,
         m_class, m_cv, m_busy, m_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_main: start=%b valid=%b data=%0d index=%0d last=%b class=%0d cv=%b busy=%b err=%b, required all 0",
               m_if.cnn_start, m_if.out_valid, m_if.out_data, m_if.out_index, m_if.out_last,
               m_class, m_cv, m_busy, m_err);
    end
    n_cmp++;
    if ({t_if.cnn_start, t_if.out_valid, t_if.out_data, t_if.out_index, t_if.out_last,
         t_class, t_cv, t_busy, t_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_tmo: start=%b valid=%b busy=%b err=%b, required all 0",
               t_if.cnn_start, t_if.out_valid, t_busy, t_err);
    end
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    n_cmp++;
    if (m_busy !== 1'b0 || m_if.cnn_start !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_release: busy=%b start=%b, required 0 0", m_busy, m_if.cnn_start);
    end
  endtask

  task automatic test_basic();
    do_reset();
    run_and_check(-16'sd5, 16'sd12, 19, 0, 1'b0, 1'b0, 32'h1234_5678);
  endtask

  task automatic test_backpressure();
    do_reset();
    run_and_check(16'sd7, 16'sd7, 4, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_snapshot();
    do_reset();
    run_and_check(-16'sd1, -16'sd2, 3, 0, 1'b0, 1'b0, 32'h0064_0064);
  endtask

  task automatic test_timeout();
    do_reset();
    run_and_check(-16'sd5, 16'sd12, 3, 0, 1'b0, 1'b0, 32'h0);
    n_cmp++;
    if (t_class !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_precondition: class_idx=%0d, required 1", t_class);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_cmp++;
      if (t_if.cnn_start !== 1'b1 || t_busy !== 1'b1 || t_err !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_wait cycle %0d: start=%b busy=%b err=%b, required 1 1 0",
                 i, t_if.cnn_start, t_busy, t_err);
      end
      tick();
    end
    n_cmp++;
    if (t_err !== 1'b1 || t_busy !== 1'b0 || t_if.cnn_start !== 1'b0 || t_class !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_expire: err=%b busy=%b start=%b class=%0d, required 1 0 0 1",
               t_err, t_busy, t_if.cnn_start, t_class);
    end
    tick();
    n_cmp++;
    if (t_err !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_sticky: err=%b, required 1", t_err);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    n_cmp++;
    if (t_err !== 1'b0 || t_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_clear: err=%b busy=%b, required 0 1", t_err, t_busy);
    end
    flat = 32'hFFFC_0003;
    for (int i = 0; i < 8; i++) tick();
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    n_cmp++;
    if (t_if.out_valid !== 1'b1 || t_err !== 1'b0 || t_if.cnn_start !== 1'b0 || t_if.out_data !== 16'sd3) begin
      n_bad++;
      $display("FAIL tmo_coincident: valid=%b err=%b start=%b data=%0d, required 1 0 0 3",
               t_if.out_valid, t_err, t_if.cnn_start, t_if.out_data);
    end
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    n_cmp++;
    if (t_cv !== 1'b1 || t_class !== 1'b0 || t_busy !== 1'b0 || t_err !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_coincident_end: cv=%b class=%0d busy=%b err=%b, required 1 0 0 0",
               t_cv, t_class, t_busy, t_err);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_and_check(16'sd10, -16'sd3, 5, 1, 1'b1, 1'b0, $urandom);
    run_req = 1'b0;
    run_and_check(-16'sd8, -16'sd7, 2, 0, 1'b0, 1'b1, $urandom);
  endtask

  task automatic test_async_reset();
    do_reset();
    run_and_check(-16'sd5, 16'sd12, 2, 0, 1'b0, 1'b0, 32'h0);
    flat = 32'h0009_0004;
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    cnn_done = 1'b1;
    tick();
    cnn_done = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (m_if.out_valid !== 1'b1 || m_if.out_index !== 1'b1 || m_if.out_data !== 16'sd9) begin
      n_bad++;
      $display("FAIL mid_stream: valid=%b index=%0d data=%0d, required 1 1 9",
               m_if.out_valid, m_if.out_index, m_if.out_data);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({m_if.cnn_start, m_if.out_valid, m_if.out_data, m_if.out_index, m_if.out_last,
         m_class, m_cv, m_busy, m_err} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: start=%b valid=%b data=%0d index=%0d last=%b class=%0d cv=%b busy=%b, required all 0",
               m_if.cnn_start, m_if.out_valid, m_if.out_data, m_if.out_index, m_if.out_last,
               m_class, m_cv, m_busy);
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    run_and_check(-16'sd20, 16'sd20, 1, 1, 1'b0, 1'b0, $urandom);
  endtask

  task automatic test_random();
    logic signed [15:0] a, b;
    do_reset();
    for (int k = 0; k < 24; k++) begin
      a = 16'($urandom);
      b = ($urandom_range(3) == 0) ? a : 16'($urandom);
      run_and_check(a, b, $urandom_range(15), $urandom_range(2), 1'b0, 1'b0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_snapshot();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
endmodule
